// File: rtl/mag_comp_seq.sv
// mag_comp_seq: sequential magnitude comparator, CHUNK bits per clock,
// MSB chunk first, start/busy/done handshake, per-operation signed mode.
// Optional feature macro: COMP_EARLY_EXIT_EN (finish on first differing chunk).
module mag_comp_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             aeqb,
  output logic             agtb,
  output logic             altb
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] TOP  = IW'(NCHUNK - 1);

  typedef enum logic {
    IDLE,
    COMPARE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_q, b_q;
  logic             signed_q;
  logic [IW-1:0]    idx, idx_next;
  logic             dec_q;      // a differing chunk has already been seen
  logic             gt_q;       // direction of that first difference
  logic [CHUNK-1:0] ca, cb;
  logic             cur_gt, cur_lt;
  logic             decided, res_gt, finish;

  assign busy = (state == COMPARE);

  // Select the current chunk; in signed mode the sign bit of the top chunk
  // is flipped so an unsigned compare orders two's complement values.
  always_comb begin
    ca = '0;
    cb = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (idx == IW'(i)) begin
        ca = a_q[i*CHUNK +: CHUNK];
        cb = b_q[i*CHUNK +: CHUNK];
      end
    end
    if (signed_q && (idx == TOP)) begin
      ca[CHUNK-1] = ~ca[CHUNK-1];
      cb[CHUNK-1] = ~cb[CHUNK-1];
    end
    cur_gt = (ca > cb);
    cur_lt = (ca < cb);
  end

  // Next-state, chunk index and finish decision.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    finish     = 1'b0;
    decided    = dec_q | cur_gt | cur_lt;
    res_gt     = dec_q ? gt_q : cur_gt;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = COMPARE;
          idx_next   = TOP;
        end
      end
      COMPARE: begin
`ifdef COMP_EARLY_EXIT_EN
        finish = (idx == '0) || decided;
`else
        finish = (idx == '0);
`endif
        if (finish) state_next = IDLE;
        else        idx_next   = idx - IW'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Operand latches, pending result, done pulse and result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      idx      <= '0;
      dec_q    <= 1'b0;
      gt_q     <= 1'b0;
      done     <= 1'b0;
      aeqb     <= 1'b0;
      agtb     <= 1'b0;
      altb     <= 1'b0;
    end else begin
      done <= 1'b0;
      idx  <= idx_next;
      if ((state == IDLE) && start) begin
        a_q      <= a;
        b_q      <= b;
        signed_q <= signed_mode;
        dec_q    <= 1'b0;
        gt_q     <= 1'b0;
      end else if (state == COMPARE) begin
        if (!dec_q && (cur_gt || cur_lt)) begin
          dec_q <= 1'b1;
          gt_q  <= cur_gt;
        end
        if (finish) begin
          done <= 1'b1;
          aeqb <= ~decided;
          agtb <= decided & res_gt;
          altb <= decided & ~res_gt;
        end
      end
    end
  end

endmodule

// File: tb/tb_mag_comp_seq.sv
// tb_mag_comp_seq: scoreboard bench for mag_comp_seq (default 16/4 instance
// plus a 12/12 single-chunk instance). Flags are packed {aeqb,agtb,altb}.
module tb_mag_comp_seq;

`ifdef COMP_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  localparam logic [2:0] F_EQ = 3'b100;
  localparam logic [2:0] F_GT = 3'b010;
  localparam logic [2:0] F_LT = 3'b001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0, signed_mode = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        busy, done, aeqb, agtb, altb;

  logic        start2 = 1'b0, sm2 = 1'b0;
  logic [11:0] a2 = '0, b2 = '0;
  logic        busy2, done2, aeqb2, agtb2, altb2;

  always #5 clk = ~clk;

  mag_comp_seq #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy), .done(done),
    .aeqb(aeqb), .agtb(agtb), .altb(altb)
  );

  mag_comp_seq #(.WIDTH(12), .CHUNK(12)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .signed_mode(sm2),
    .a(a2), .b(b2), .busy(busy2), .done(done2),
    .aeqb(aeqb2), .agtb(agtb2), .altb(altb2)
  );

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  logic [2:0] qf[$], q2f[$];
  int         qc[$], q2c[$];
  logic [2:0] last;

  typedef struct {
    logic [15:0] va, vb;
    logic        sm;
    logic [2:0]  f;
    int          lee, lfull;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor for the 16-bit instance: pop expectation on every done.
  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (done) begin
      if (qf.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        logic [2:0] ef;
        int ec;
        ef = qf.pop_front();
        ec = qc.pop_front();
        chk("flags", int'({aeqb, agtb, altb}), int'(ef));
        chk("done_cycle", cyc, ec);
      end
    end
  end

  // Monitor for the single-chunk instance.
  always begin
    @(posedge clk);
    #1;
    if (done2) begin
      if (q2f.size() == 0) begin
        chk("unexpected_done2", 1, 0);
      end else begin
        logic [2:0] ef;
        int ec;
        ef = q2f.pop_front();
        ec = q2c.pop_front();
        chk("flags2", int'({aeqb2, agtb2, altb2}), int'(ef));
        chk("done_cycle2", cyc, ec);
      end
    end
  end

  task automatic issue(input logic [15:0] va, input logic [15:0] vb,
                       input logic vsm, input logic [2:0] f, input int lat,
                       input bit push);
    @(negedge clk);
    a = va; b = vb; signed_mode = vsm; start = 1'b1;
    if (push) begin
      qf.push_back(f);
      qc.push_back(cyc + 1 + lat);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue2(input logic [11:0] va, input logic [11:0] vb,
                        input logic vsm, input logic [2:0] f);
    @(negedge clk);
    a2 = va; b2 = vb; sm2 = vsm; start2 = 1'b1;
    q2f.push_back(f);
    q2c.push_back(cyc + 2);
    @(negedge clk);
    start2 = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (((qf.size() + q2f.size()) > 0) && (t < 100)) begin
      @(negedge clk);
      t++;
    end
    chk("drain", qf.size() + q2f.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[8];
    int nb, l1;
    vt[0] = '{16'h1234, 16'h1234, 1'b0, F_EQ, 4, 4};
    vt[1] = '{16'h8000, 16'h7FFF, 1'b0, F_GT, 1, 4};
    vt[2] = '{16'h8000, 16'h7FFF, 1'b1, F_LT, 1, 4};
    vt[3] = '{16'h1235, 16'h1234, 1'b0, F_GT, 4, 4};
    vt[4] = '{16'h1234, 16'h1235, 1'b0, F_LT, 4, 4};
    vt[5] = '{16'h12F0, 16'h1200, 1'b0, F_GT, 3, 4};
    vt[6] = '{16'hFFFF, 16'hFFFE, 1'b1, F_GT, 4, 4};
    vt[7] = '{16'h7FFF, 16'h8000, 1'b1, F_GT, 1, 4};

    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_flags", int'({aeqb, agtb, altb}), 0);
    chk("rst_flags2", int'({busy2, done2, aeqb2, agtb2, altb2}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last = 3'b000;

    // Equal operands: busy must stay high for exactly NCHUNK cycles.
    issue(vt[0].va, vt[0].vb, vt[0].sm, vt[0].f, EE ? vt[0].lee : vt[0].lfull, 1'b1);
    chk("flags_hold", int'({aeqb, agtb, altb}), int'(last));
    nb = 0;
    while (busy && nb < 20) begin
      nb++;
      @(negedge clk);
    end
    chk("busy_len", nb, 4);
    drain();
    last = vt[0].f;

    for (int i = 1; i < 8; i++) begin
      issue(vt[i].va, vt[i].vb, vt[i].sm, vt[i].f, EE ? vt[i].lee : vt[i].lfull, 1'b1);
      chk("flags_hold", int'({aeqb, agtb, altb}), int'(last));
      drain();
      last = vt[i].f;
    end

    // start while busy with new operands must be ignored.
    issue(16'h1235, 16'h1234, 1'b0, F_GT, 4, 1'b1);
    a = 16'h0000; b = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (6) @(negedge clk);
    chk("ignored_busy", int'(busy), 0);
    last = F_GT;

    // start held high through done: second op accepted at the done cycle.
    l1 = EE ? 1 : 4;
    @(negedge clk);
    a = 16'h8000; b = 16'h7FFF; signed_mode = 1'b0; start = 1'b1;
    qf.push_back(F_GT);
    qc.push_back(cyc + 1 + l1);
    @(negedge clk);
    a = 16'h0001; b = 16'h0002;
    qf.push_back(F_LT);
    qc.push_back(cyc + l1 + 1 + 4);
    repeat (l1 + 1) @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", int'(busy), 1);
    drain();
    last = F_LT;

    // Reset in the middle of a compare: no done, everything cleared.
    issue(16'h1234, 16'h1235, 1'b0, F_LT, 4, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_flags", int'({aeqb, agtb, altb}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'h0001, 16'h0002, 1'b0, F_LT, 4, 1'b1);
    chk("flags_hold", int'({aeqb, agtb, altb}), 0);
    drain();

    // Single-chunk instance: latency 1 in both configurations.
    issue2(12'hFFF, 12'h001, 1'b1, F_LT);
    drain();
    issue2(12'hFFF, 12'h001, 1'b0, F_GT);
    drain();
    issue2(12'hABC, 12'hABC, 1'b1, F_EQ);
    drain();

    repeat (3) @(negedge clk);
    chk("queue_empty", qf.size() + q2f.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
